q_accum: RTL and testbench
==========================

# q_accum

Sequential Q-format accumulator that sits directly downstream of the fixed-point multiplier. It sums a frame of LEN sign-magnitude Q(Q,N) products into one dot-product result, using a valid/ready handshake on both sides. Each frame produces one sign-magnitude result in the same Q(Q,N) format, plus an overflow flag. It is the consumer stage that turns per-sample products into filter taps and dot products.

## Interface
- Q, 23: fractional bits of input and output words.
- N, 32: total word width; bit N-1 is the sign, bits N-2:0 are the magnitude.
- LEN, 8: products per frame; legal range 2..256.
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- clr  in  1  synchronous frame abort; highest priority after reset.
- in_data  in  N  sign-magnitude product.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample.
- out_data  out  N  sign-magnitude frame sum.
- out_ovf  out  1  frame sum exceeded the representable magnitude.
- out_valid  out  1  out_data/out_ovf are valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- Accept rule: a sample is accepted on a rising edge where in_valid && in_ready.
- Each accepted sample is converted sign-magnitude to two's complement and added to the accumulator.
  - The accumulator is N+clog2(LEN) bits wide, two's complement, so it cannot wrap internally.
  - Negative zero (sign=1, magnitude=0) is treated as zero.
- States:
  - IDLE: accumulator = 0, count = 0, in_ready = 1. First accept → ACCUM, with count = 1.
  - ACCUM: in_ready = 1. Each accept increments count. The accept that makes count == LEN → OUTPUT.
  - OUTPUT: in_ready = 0, out_valid = 1. On out_valid && out_ready → IDLE.
- Result packing, on the transition into OUTPUT:
  - The sign-magnitude conversion of the final sum is registered into out_data and out_ovf.
  - Any sum that is zero is output as +0 (sign bit 0).
  - out_ovf = 1 when |sum| > 2^(N-1)-1.
- clr: on an edge with clr = 1, the state goes to IDLE, and the accumulator and count are zeroed.
  - out_valid drops, and any pending result is discarded.
  - An in_valid on the same edge is not accepted.
- A sample is never dropped or double-counted. in_data is ignored when in_valid = 0.

## Timing
- Reset values: state IDLE, accumulator 0, count 0, out_data 0, out_ovf 0, out_valid 0, in_ready 1 (decoded from IDLE).
- Throughput: one sample per cycle while in IDLE or ACCUM.
- Latency: the LEN-th accept at edge k gives out_valid = 1 from edge k onward, i.e. visible in the cycle after that edge.
- Minimum result hold: one cycle.
- Back-pressure: while out_valid = 1 and out_ready = 0, out_data and out_ovf are held stable and in_ready stays 0.
- Frame turnaround: the result handshake at edge m returns the state to IDLE, so in_ready = 1 in the next cycle. The minimum frame period is LEN+1 cycles.
- Reset mid-frame: the block reaches reset values immediately and asynchronously. Release takes effect on the next clk edge.
- in_ready and out_valid are pure state decodes, with no combinational path from in_valid or out_ready.

## Configuration
- Q_ACCUM_SAT_EN defined: on overflow, out_data = sign of the sum with magnitude 2^(N-1)-1 (full-scale saturation), and out_ovf = 1.
- Q_ACCUM_SAT_EN undefined: on overflow, out_data = sign of the sum with the magnitude truncated to its low N-1 bits, and out_ovf = 1.
- In both builds, out_ovf is identical.

## Structure
- Shared package q_fixed_pkg holds:
  - the state enum (IDLE, ACCUM, OUTPUT);
  - the sm_to_tc and tc_to_sm conversion functions;
  - a width helper for N+clog2(LEN).
- One sub-module, q_sat_pack, converts the wide two's-complement sum to an N-bit sign-magnitude value and produces the overflow flag. The saturation logic guarded by the macro lives there.
- Other Q-format stages reuse q_fixed_pkg.

## Test plan
- Defaults (Q=23, N=32, LEN=8) throughout.
- Eight accepts of 0x00800000 (+1.0) → out_data 0x04000000 (+8.0), out_ovf 0, out_valid on the cycle after the 8th accept.
- Four pairs of 0x00C00000 (+1.5) and 0x80400000 (−0.5) → out_data 0x02000000 (+4.0), out_ovf 0.
- Eight accepts of 0x7FFFFFFF → out_ovf 1. With Q_ACCUM_SAT_EN, out_data 0x7FFFFFFF. Without it, out_data 0x7FFFFFF8.
- Eight accepts of 0x80000000 (−0) → out_data 0x00000000, sign bit 0.
- Result back-pressure: hold out_ready = 0 for 5 cycles after a result → out_data stable, in_ready 0 throughout; release → in_ready 1 the next cycle and the next frame sums correctly.
- Three accepts of +1.0, then clr = 1 for one cycle (or rst_n pulsed low mid-cycle), then eight accepts of 0x01000000 (+2.0) → out_data 0x08000000 (+16.0); the aborted samples contribute nothing.

Source files
------------

// File: rtl/q_fixed_pkg.sv
// Shared Q-format helpers: accumulator state encoding, sign-magnitude <-> two's-complement
// conversion on a fixed working width, and width helpers for downstream stages.
package q_fixed_pkg;

    // Working width of the conversion helpers; callers extend into and slice out of it.
    localparam int unsigned MaxW = 64;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StOutput
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned acc_width(input int unsigned n, input int unsigned len);
        return n + clog2(len);
    endfunction

    // Sign-magnitude word of width n (zero-extended into sm) to MaxW-bit two's complement.
    // Negative zero comes out as zero.
    function automatic logic [MaxW-1:0] sm_to_tc(input logic [MaxW-1:0] sm,
                                                 input int unsigned n);
        logic [MaxW-1:0] mask;
        logic [MaxW-1:0] mag;
        logic            sign;
        mask = {MaxW{1'b1}} >> (MaxW - n + 1);
        mag  = sm & mask;
        sign = |(sm & (64'd1 << (n - 1)));
        return sign ? (~mag + 64'd1) : mag;
    endfunction

    // MaxW-bit two's complement to sign-magnitude: bit MaxW-1 is the sign, the rest the
    // magnitude. Input must be sign-extended from at most MaxW-1 bits so the magnitude fits.
    function automatic logic [MaxW-1:0] tc_to_sm(input logic [MaxW-1:0] tc);
        logic [MaxW-2:0] mag;
        mag = tc[MaxW-1] ? (~tc[MaxW-2:0] + 63'd1) : tc[MaxW-2:0];
        return {tc[MaxW-1], mag};
    endfunction

endpackage

// File: rtl/q_sat_pack.sv
// Packs a wide two's-complement sum into an N-bit sign-magnitude word plus overflow flag.
// Define Q_ACCUM_SAT_EN for full-scale saturation on overflow; otherwise the magnitude wraps.
module q_sat_pack
    import q_fixed_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned W = 35
) (
    input  logic [W-1:0] sum,
    output logic [N-1:0] sm,
    output logic         ovf
);

    logic [MaxW-1:0] sum_ext;
    logic [MaxW-1:0] sm_wide;
    logic            sign;

    assign sum_ext = {{(MaxW - W){sum[W-1]}}, sum};
    assign sm_wide = tc_to_sm(sum_ext);
    assign sign    = sm_wide[MaxW-1];
    // Any magnitude bit at or above N-1 means |sum| > 2^(N-1)-1.
    assign ovf     = |sm_wide[MaxW-2:N-1];

`ifdef Q_ACCUM_SAT_EN
    assign sm = ovf ? {sign, {(N - 1){1'b1}}} : {sign, sm_wide[N-2:0]};
`else
    assign sm = {sign, sm_wide[N-2:0]};
`endif

endmodule

// File: rtl/q_accum.sv
// Frame accumulator: sums LEN sign-magnitude Q(Q,N) products into one sign-magnitude result.
// Overflow handling of the packed result depends on Q_ACCUM_SAT_EN (see q_sat_pack).
module q_accum
    import q_fixed_pkg::*;
#(
    parameter int unsigned Q   = 23,
    parameter int unsigned N   = 32,
    parameter int unsigned LEN = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned W    = acc_width(N, LEN);
    localparam int unsigned CntW = clog2(LEN + 1);

    if (Q >= N) begin : g_bad_q
        $error("q_accum: Q must be smaller than N");
    end
    if (LEN < 2 || LEN > 256) begin : g_bad_len
        $error("q_accum: LEN must be in 2..256");
    end
    if (W >= MaxW) begin : g_bad_w
        $error("q_accum: accumulator width exceeds conversion width");
    end

    state_e          state_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    acc_d;
    logic [CntW-1:0] cnt_q;
    logic [N-1:0]    out_data_q;
    logic            out_ovf_q;
    logic [N-1:0]    pack_sm;
    logic            pack_ovf;
    logic [MaxW-1:0] sample_tc;
    logic            accept;
    logic            last;

    assign in_ready  = (state_q == StIdle) || (state_q == StAccum);
    assign out_valid = (state_q == StOutput);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // clr wins over a same-edge sample.
    assign accept    = in_valid && in_ready && !clr;
    assign last      = (cnt_q == CntW'(LEN - 1));

    assign sample_tc = sm_to_tc({{(MaxW - N){1'b0}}, in_data}, N);
    assign acc_d     = acc_q + sample_tc[W-1:0];

    // A product magnitude is below 2^(N-1), so the bits above the accumulator are pure sign.
    always_comb begin : p_sample_ext
        assert ((sample_tc[MaxW-1:W-1] == '0) || (&sample_tc[MaxW-1:W-1]));
    end

    q_sat_pack #(
        .N(N),
        .W(W)
    ) u_pack (
        .sum(acc_d),
        .sm (pack_sm),
        .ovf(pack_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else if (clr) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle, StAccum: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last) begin
                            state_q    <= StOutput;
                            out_data_q <= pack_sm;
                            out_ovf_q  <= pack_ovf;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StOutput: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_q_accum.sv
// Directed bench for q_accum at defaults (Q=23, N=32, LEN=8); expectations are hand-computed.
module tb_q_accum;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    q_accum #(
        .Q  (23),
        .N  (32),
        .LEN(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic take_result(input string tag, input logic [31:0] exp_data,
                               input logic exp_ovf);
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
        check({tag, " out_data"}, out_data, exp_data);
        check({tag, " out_ovf"}, {31'd0, out_ovf}, {31'd0, exp_ovf});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, " in_ready back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic frame(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data, input logic exp_ovf);
        for (int i = 0; i < 4; i++) begin
            push(a);
            push(b);
        end
        take_result(tag, exp_data, exp_ovf);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        #12;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_data", out_data, 32'h0000_0000);
        check("rst out_ovf", {31'd0, out_ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // +1.0 x8, with latency check after the 7th accept
        for (int i = 0; i < 8; i++) begin
            push(32'h0080_0000);
            if (i == 6) check("p1 no early valid", {31'd0, out_valid}, 32'd0);
        end
        take_result("p1", 32'h0400_0000, 1'b0);

        frame("mix", 32'h00C0_0000, 32'h8040_0000, 32'h0200_0000, 1'b0);
        frame("negmix", 32'h80C0_0000, 32'h0040_0000, 32'h8200_0000, 1'b0);
`ifdef Q_ACCUM_SAT_EN
        frame("ovf pos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        frame("ovf neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
`else
        frame("ovf pos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFF8, 1'b1);
        frame("ovf neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1);
`endif
        frame("negzero", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);

        // Back-pressure: offered samples during OUTPUT must not be taken
        for (int i = 0; i < 8; i++) push(32'h0080_0000);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0080_0000;
            @(posedge clk);
            #1;
            check("bp out_data hold", out_data, 32'h0400_0000);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        take_result("bp", 32'h0400_0000, 1'b0);
        frame("after bp", 32'h8080_0000, 32'h8080_0000, 32'h8400_0000, 1'b0);

        // clr mid-frame, with a competing sample on the same edge
        for (int i = 0; i < 3; i++) push(32'h0080_0000);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0080_0000;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr in_ready", {31'd0, in_ready}, 32'd1);
        check("clr out_valid", {31'd0, out_valid}, 32'd0);
        frame("after clr", 32'h0100_0000, 32'h0100_0000, 32'h0800_0000, 1'b0);

        // clr while a result is pending
        for (int i = 0; i < 8; i++) push(32'h0080_0000);
        check("pend out_valid", {31'd0, out_valid}, 32'd1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr pend out_valid", {31'd0, out_valid}, 32'd0);
        check("clr pend in_ready", {31'd0, in_ready}, 32'd1);
        frame("after clr pend", 32'h0100_0000, 32'h0100_0000, 32'h0800_0000, 1'b0);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) push(32'h0080_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst in_ready", {31'd0, in_ready}, 32'd1);
        check("arst out_valid", {31'd0, out_valid}, 32'd0);
        check("arst out_data", out_data, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame("after arst", 32'h0100_0000, 32'h0100_0000, 32'h0800_0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
